// File: rtl/amo_pkg.sv
// Shared AMO definitions: opcode encoding, reservation slot layout and lane selection.
package amo_pkg;

    typedef enum logic [3:0] {
        AMONone = 4'h0,
        AMOSwap = 4'h1,
        AMOAdd  = 4'h2,
        AMOAnd  = 4'h3,
        AMOOr   = 4'h4,
        AMOXor  = 4'h5,
        AMOMax  = 4'h6,
        AMOMaxu = 4'h7,
        AMOMin  = 4'h8,
        AMOMinu = 4'h9,
        AMOCAS  = 4'hA,
        AMOLr   = 4'hB,
        AMOSc   = 4'hC
    } amo_op_t;

    localparam int unsigned ResvAddrWidth = 32;
    localparam int unsigned MaxLanes      = 32;
    localparam int unsigned LaneIdxWidth  = 5;

    typedef struct packed {
        logic                     valid;
        logic [ResvAddrWidth-1:0] addr;
    } reservation_t;

    // Lowest lane with any byte enabled; lane 0 when none is.
    function automatic logic [LaneIdxWidth-1:0] lowest_lane(input logic [MaxLanes-1:0] nib_any);
        logic [LaneIdxWidth-1:0] lane;
        lane = '0;
        for (int i = MaxLanes - 1; i >= 0; i--) begin
            if (nib_any[i]) lane = LaneIdxWidth'(i);
        end
        return lane;
    endfunction

endpackage

// File: rtl/amo_alu.sv
// Combinational 32-bit AMO ALU: old value a, operand b, CAS swap value -> value to write back.
module amo_alu
    import amo_pkg::*;
(
    input  logic [3:0]  op_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic [31:0] swap_i,
    output logic [31:0] result_o
);

    logic        signed_cmp;
    logic [32:0] diff;
    logic        a_lt_b;

    always_comb begin
        signed_cmp = (op_i == AMOMax) || (op_i == AMOMin);
        // Borrow of a 33-bit subtract gives a<b for both sign- and zero-extended operands.
        diff   = {signed_cmp & a_i[31], a_i} - {signed_cmp & b_i[31], b_i};
        a_lt_b = diff[32];
        result_o = a_i;
        case (op_i)
            AMOSwap, AMOSc:  result_o = b_i;
            AMOAdd:          result_o = a_i + b_i;
            AMOAnd:          result_o = a_i & b_i;
            AMOOr:           result_o = a_i | b_i;
            AMOXor:          result_o = a_i ^ b_i;
            AMOMax, AMOMaxu: result_o = a_lt_b ? b_i : a_i;
            AMOMin, AMOMinu: result_o = a_lt_b ? a_i : b_i;
            AMOCAS:          result_o = (a_i == b_i) ? swap_i : a_i;
            default:         result_o = a_i;
        endcase
    end

endmodule

// File: rtl/amo_shim_mc.sv
// AMO shim between an N-core port and one SRAM bank: read-modify-write AMOs plus per-core LR/SC reservations.
module amo_shim_mc
    import amo_pkg::*;
#(
    parameter int unsigned AddrMemWidth = 32,
    parameter int unsigned DataWidth    = 64,
    parameter int unsigned NumCores     = 4
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        in_req_i,
    output logic                        in_gnt_o,
    input  logic [$clog2(NumCores)-1:0] in_id_i,
    input  logic [AddrMemWidth-1:0]     in_add_i,
    input  logic [3:0]                  in_amo_i,
    input  logic                        in_wen_i,
    input  logic [DataWidth-1:0]        in_wdata_i,
    input  logic [DataWidth/8-1:0]      in_be_i,
    output logic [DataWidth-1:0]        in_rdata_o,
    output logic                        out_req_o,
    input  logic                        out_gnt_i,
    output logic [AddrMemWidth-1:0]     out_add_o,
    output logic                        out_wen_o,
    output logic [DataWidth-1:0]        out_wdata_o,
    output logic [DataWidth/8-1:0]      out_be_o,
    input  logic [DataWidth-1:0]        out_rdata_i
);

    localparam int unsigned NumLanes = DataWidth / 32;
    localparam int unsigned LaneW    = (NumLanes > 1) ? $clog2(NumLanes) : 1;
    localparam int unsigned IdW      = $clog2(NumCores);

    typedef enum logic [1:0] {Idle, DoAMO, WaitWr} state_e;

    state_e            state_q, state_d;
    logic [3:0]        op_q, op_d;
    logic [AddrMemWidth-1:0] addr_q, addr_d;
    logic [LaneW-1:0]  lane_q, lane_d;
    logic [IdW-1:0]    id_q, id_d;
    logic [31:0]       b_q, b_d, swap_q, swap_d, wb_q, wb_d;
    reservation_t      resv_q [NumCores];
    reservation_t      resv_d [NumCores];

    logic              op_valid, is_lr, is_rmw, is_store, sc_ok;
    logic [MaxLanes-1:0] nib_any;
    logic [LaneW-1:0]  sel_lane;
    logic [31:0]       b_in, swap_in, old_val, alu_res;

    function automatic logic [DataWidth-1:0] place(input logic [31:0] v, input logic [LaneW-1:0] lane);
        logic [DataWidth-1:0] r;
        r = '0;
        for (int l = 0; l < NumLanes; l++) begin
            if (lane == LaneW'(l)) r[l*32 +: 32] = v;
        end
        return r;
    endfunction

    function automatic logic [DataWidth/8-1:0] lane_be(input logic [LaneW-1:0] lane);
        logic [DataWidth/8-1:0] r;
        r = '0;
        for (int l = 0; l < NumLanes; l++) begin
            if (lane == LaneW'(l)) r[l*4 +: 4] = 4'hF;
        end
        return r;
    endfunction

    // Request decode and operand extraction from the selected lane.
    always_comb begin
        op_valid = (in_amo_i >= 4'h1) && (in_amo_i <= 4'hC);
        is_lr    = (in_amo_i == AMOLr);
        is_rmw   = op_valid && !is_lr;
        is_store = !op_valid && in_wen_i;
        nib_any  = '0;
        for (int l = 0; l < NumLanes; l++) nib_any[l] = |in_be_i[l*4 +: 4];
        sel_lane = LaneW'(lowest_lane(nib_any));
        b_in     = '0;
        swap_in  = '0;
        old_val  = '0;
        for (int l = 0; l < NumLanes; l++) begin
            if (sel_lane == LaneW'(l)) begin
                b_in    = in_wdata_i[l*32 +: 32];
                swap_in = in_wdata_i[((l + 1) % NumLanes)*32 +: 32];
            end
            if (lane_q == LaneW'(l)) old_val = out_rdata_i[l*32 +: 32];
        end
        sc_ok = resv_q[id_q].valid && (resv_q[id_q].addr == ResvAddrWidth'(addr_q));
    end

    amo_alu u_alu (
        .op_i    (op_q),
        .a_i     (old_val),
        .b_i     (b_q),
        .swap_i  (swap_q),
        .result_o(alu_res)
    );

    // Next state, reservation updates and bank/port muxing.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        addr_d      = addr_q;
        lane_d      = lane_q;
        id_d        = id_q;
        b_d         = b_q;
        swap_d      = swap_q;
        wb_d        = wb_q;
        resv_d      = resv_q;
        out_req_o   = in_req_i;
        out_add_o   = in_add_i;
        out_wen_o   = in_wen_i && !op_valid;
        out_wdata_o = in_wdata_i;
        out_be_o    = in_be_i;
        in_gnt_o    = out_gnt_i;
        in_rdata_o  = out_rdata_i;

        case (state_q)
            Idle: begin
                if (in_req_i && out_gnt_i) begin
                    if (is_store) begin
                        for (int c = 0; c < NumCores; c++) begin
                            if (resv_q[c].addr == ResvAddrWidth'(in_add_i)) resv_d[c].valid = 1'b0;
                        end
                    end
                    // Set after the clear so a same-cycle LR keeps its slot.
                    if (is_lr) resv_d[in_id_i] = '{valid: 1'b1, addr: ResvAddrWidth'(in_add_i)};
                    if (is_rmw) begin
                        op_d    = in_amo_i;
                        addr_d  = in_add_i;
                        lane_d  = sel_lane;
                        id_d    = in_id_i;
                        b_d     = b_in;
                        swap_d  = swap_in;
                        state_d = DoAMO;
                    end
                end
            end
            DoAMO: begin
                in_gnt_o    = 1'b0;
                in_rdata_o  = place(old_val, lane_q);
                out_req_o   = 1'b1;
                out_add_o   = addr_q;
                out_wen_o   = 1'b1;
                out_be_o    = lane_be(lane_q);
                out_wdata_o = place(alu_res, lane_q);
                if (op_q == AMOSc) begin
                    in_rdata_o        = place({31'b0, ~sc_ok}, lane_q);
                    resv_d[id_q].valid = 1'b0;
                end
                if (op_q == AMOSc && !sc_ok) begin
                    out_req_o = 1'b0;
                    out_wen_o = 1'b0;
                    state_d   = Idle;
                end else begin
                    for (int c = 0; c < NumCores; c++) begin
                        if (resv_q[c].addr == ResvAddrWidth'(addr_q)) resv_d[c].valid = 1'b0;
                    end
                    if (out_gnt_i) begin
                        state_d = Idle;
                    end else begin
                        wb_d    = alu_res;
                        state_d = WaitWr;
                    end
                end
            end
            WaitWr: begin
                in_gnt_o    = 1'b0;
                out_req_o   = 1'b1;
                out_add_o   = addr_q;
                out_wen_o   = 1'b1;
                out_be_o    = lane_be(lane_q);
                out_wdata_o = place(wb_q, lane_q);
                if (out_gnt_i) state_d = Idle;
            end
            default: state_d = Idle;
        endcase

        // Reset suppresses any bank access, including a pending write-back.
        if (rst_i) begin
            in_gnt_o  = 1'b0;
            out_req_o = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= Idle;
            op_q    <= '0;
            addr_q  <= '0;
            lane_q  <= '0;
            id_q    <= '0;
            b_q     <= '0;
            swap_q  <= '0;
            wb_q    <= '0;
            for (int c = 0; c < NumCores; c++) resv_q[c] <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            lane_q  <= lane_d;
            id_q    <= id_d;
            b_q     <= b_d;
            swap_q  <= swap_d;
            wb_q    <= wb_d;
            for (int c = 0; c < NumCores; c++) resv_q[c] <= resv_d[c];
        end
    end

endmodule

// File: tb/tb_amo_shim_mc.sv
// Directed bench for amo_shim_mc with a 1-cycle-latency SRAM model behind it.
module tb_amo_shim_mc;

    localparam logic [3:0] OP_NONE = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h2;
    localparam logic [3:0] OP_XOR  = 4'h5;
    localparam logic [3:0] OP_MAX  = 4'h6;
    localparam logic [3:0] OP_MAXU = 4'h7;
    localparam logic [3:0] OP_CAS  = 4'hA;
    localparam logic [3:0] OP_LR   = 4'hB;
    localparam logic [3:0] OP_SC   = 4'hC;
    localparam logic [63:0] RST_RDATA = 64'hDEADBEEF_00001234;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_req, in_gnt, in_wen, out_req, out_gnt, out_wen;
    logic [1:0]  in_id;
    logic [31:0] in_add, out_add;
    logic [3:0]  in_amo;
    logic [63:0] in_wdata, in_rdata, out_wdata, out_rdata;
    logic [7:0]  in_be, out_be;
    logic [63:0] mem [0:127];
    int          wr_cnt = 0;
    int          checks = 0;
    int          errors = 0;
    int          wc;

    always #5 clk = ~clk;

    amo_shim_mc #(.AddrMemWidth(32), .DataWidth(64), .NumCores(4)) dut (
        .clk_i(clk), .rst_i(rst),
        .in_req_i(in_req), .in_gnt_o(in_gnt), .in_id_i(in_id), .in_add_i(in_add),
        .in_amo_i(in_amo), .in_wen_i(in_wen), .in_wdata_i(in_wdata), .in_be_i(in_be),
        .in_rdata_o(in_rdata),
        .out_req_o(out_req), .out_gnt_i(out_gnt), .out_add_o(out_add), .out_wen_o(out_wen),
        .out_wdata_o(out_wdata), .out_be_o(out_be), .out_rdata_i(out_rdata)
    );

    // SRAM bank model: byte-masked writes, read data one cycle after grant.
    always @(posedge clk) begin
        if (rst) begin
            out_rdata <= RST_RDATA;
        end else if (out_req && out_gnt) begin
            if (out_wen) begin
                for (int i = 0; i < 8; i++) begin
                    if (out_be[i]) mem[out_add[6:0]][i*8 +: 8] <= out_wdata[i*8 +: 8];
                end
                wr_cnt <= wr_cnt + 1;
            end else begin
                out_rdata <= mem[out_add[6:0]];
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [1:0] id,
                         input logic wen, input logic [63:0] wd, input logic [7:0] be);
        in_req = 1'b1; in_amo = op; in_add = a; in_id = id; in_wen = wen; in_wdata = wd; in_be = be;
    endtask

    task automatic release_req();
        in_req = 1'b0; in_amo = OP_NONE; in_wen = 1'b0; in_be = 8'h00;
    endtask

    task automatic store(input logic [31:0] a, input logic [63:0] wd, input logic [1:0] id);
        drive(OP_NONE, a, id, 1'b1, wd, 8'hFF);
        tick();
        release_req();
    endtask

    // Issue an AMO and stop at the negedge of its DoAMO cycle.
    task automatic amo_issue(input logic [3:0] op, input logic [31:0] a, input logic [1:0] id,
                             input logic [63:0] wd, input logic [7:0] be);
        drive(op, a, id, 1'b0, wd, be);
        tick();
        release_req();
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "CHECKS %0d ERRORS %0d", checks, errors + 1);
    end

    initial begin
        rst = 1'b1; out_gnt = 1'b1; in_id = '0; in_add = '0; in_wdata = '0;
        release_req();
        drive(OP_NONE, 32'h10, 2'd0, 1'b0, 64'h0, 8'hFF);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_gnt", 64'(in_gnt), 64'd0);
        chk("reset_req", 64'(out_req), 64'd0);
        chk("reset_rdata", in_rdata, RST_RDATA);
        tick();
        rst = 1'b0;
        release_req();

        drive(OP_NONE, 32'h11, 2'd0, 1'b0, 64'h0, 8'h0F);
        @(negedge clk);
        chk("pass_add", 64'(out_add), 64'h11);
        chk("pass_gnt", 64'(in_gnt), 64'd1);
        tick();
        release_req();

        store(32'h0, 64'hFFFFFFFF_00000005, 2'd3);
        store(32'h1, 64'h80000000, 2'd3);
        store(32'h2, 64'h80000000, 2'd3);
        store(32'h3, 64'd7, 2'd3);
        store(32'h40, 64'd100, 2'd3);
        store(32'h5, 64'd10, 2'd3);
        store(32'h6, 64'd20, 2'd3);
        store(32'h9, 64'hF0, 2'd3);
        store(32'h20, 64'd5, 2'd3);

        drive(OP_ADD, 32'h0, 2'd0, 1'b1, {32'd3, 32'd0}, 8'hF0);
        @(negedge clk);
        chk("add_wen_forced", 64'(out_wen), 64'd0);
        chk("add_gnt", 64'(in_gnt), 64'd1);
        tick();
        release_req();
        @(negedge clk);
        chk("add_busy", 64'(in_gnt), 64'd0);
        chk("add_rdata", in_rdata, 64'hFFFFFFFF_00000000);
        chk("add_be", 64'(out_be), 64'hF0);
        chk("add_wdata", out_wdata, 64'h00000002_00000000);
        tick();
        @(negedge clk);
        chk("add_idle", 64'(in_gnt), 64'd1);
        chk("add_mem", mem[0], 64'h00000002_00000005);

        amo_issue(OP_MAXU, 32'h1, 2'd0, 64'd1, 8'h0F);
        chk("maxu_rdata", in_rdata, 64'h80000000);
        tick();
        chk("maxu_mem", mem[1], 64'h80000000);
        amo_issue(OP_MAX, 32'h2, 2'd0, 64'd1, 8'h0F);
        chk("max_rdata", in_rdata, 64'h80000000);
        tick();
        chk("max_mem", mem[2], 64'h1);

        amo_issue(OP_CAS, 32'h3, 2'd0, {32'd9, 32'd7}, 8'h0F);
        chk("cas_hit_rdata", in_rdata, 64'd7);
        tick();
        chk("cas_hit_mem", mem[3], 64'd9);
        amo_issue(OP_CAS, 32'h3, 2'd0, {32'd9, 32'd8}, 8'h0F);
        chk("cas_miss_rdata", in_rdata, 64'd9);
        tick();
        chk("cas_miss_mem", mem[3], 64'd9);

        drive(OP_LR, 32'h40, 2'd0, 1'b0, 64'h0, 8'h0F);
        tick();
        release_req();
        @(negedge clk);
        chk("lr_rdata", in_rdata, 64'd100);
        store(32'h40, 64'd55, 2'd1);
        wc = wr_cnt;
        amo_issue(OP_SC, 32'h40, 2'd0, 64'd77, 8'h0F);
        chk("sc_fail_rdata", in_rdata, 64'd1);
        chk("sc_fail_req", 64'(out_req), 64'd0);
        tick();
        chk("sc_fail_mem", mem[8'h40], 64'd55);
        chk("sc_fail_nowr", 64'(wr_cnt), 64'(wc));
        drive(OP_LR, 32'h40, 2'd0, 1'b0, 64'h0, 8'h0F);
        tick();
        release_req();
        amo_issue(OP_SC, 32'h40, 2'd0, 64'd77, 8'h0F);
        chk("sc_ok_rdata", in_rdata, 64'd0);
        chk("sc_ok_req", 64'(out_req), 64'd1);
        tick();
        chk("sc_ok_mem", mem[8'h40], 64'd77);

        amo_issue(OP_XOR, 32'h9, 2'd1, 64'hFF, 8'h00);
        chk("xor_be0_rdata", in_rdata, 64'hF0);
        chk("xor_be0_be", 64'(out_be), 64'h0F);
        tick();
        chk("xor_be0_mem", mem[9], 64'h0F);
        drive(4'hD, 32'h8, 2'd2, 1'b1, 64'hABCD, 8'hFF);
        @(negedge clk);
        chk("opd_wen", 64'(out_wen), 64'd1);
        tick();
        release_req();
        @(negedge clk);
        chk("opd_idle", 64'(in_gnt), 64'd1);
        chk("opd_mem", mem[8], 64'hABCD);

        wc = wr_cnt;
        drive(OP_ADD, 32'h5, 2'd0, 1'b0, 64'd1, 8'h0F);
        tick();
        release_req();
        out_gnt = 1'b0;
        drive(OP_NONE, 32'h7, 2'd1, 1'b0, 64'h0, 8'hFF);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("ww_gnt", 64'(in_gnt), 64'd0);
            chk("ww_add", 64'(out_add), 64'h5);
            chk("ww_wdata", out_wdata, 64'd11);
            chk("ww_req", 64'(out_req & out_wen), 64'd1);
            tick();
        end
        out_gnt = 1'b1;
        @(negedge clk);
        chk("ww_last_gnt", 64'(in_gnt), 64'd0);
        chk("ww_not_yet", 64'(wr_cnt), 64'(wc));
        tick();
        @(negedge clk);
        chk("ww_next_gnt", 64'(in_gnt), 64'd1);
        chk("ww_next_add", 64'(out_add), 64'h7);
        chk("ww_once", 64'(wr_cnt), 64'(wc + 1));
        chk("ww_mem", mem[5], 64'd11);
        tick();
        release_req();

        drive(OP_LR, 32'h20, 2'd2, 1'b0, 64'h0, 8'h0F);
        tick();
        release_req();
        wc = wr_cnt;
        amo_issue(OP_ADD, 32'h6, 2'd0, 64'd5, 8'h0F);
        rst = 1'b1;
        #1;
        chk("rst_noreq", 64'(out_req), 64'd0);
        tick();
        rst = 1'b0;
        chk("rst_mem", mem[6], 64'd20);
        chk("rst_nowr", 64'(wr_cnt), 64'(wc));
        amo_issue(OP_SC, 32'h20, 2'd2, 64'd1, 8'h0F);
        chk("rst_sc_fail", in_rdata, 64'd1);
        tick();
        chk("rst_sc_mem", mem[8'h20], 64'd5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
